// File: rtl/serial_bus_arbiter.sv
// Two-master arbiter for the bit-serial slave bus: round-robin grant, serial
// slave-select prefix decode, request/response routing and a hold-time limit.
module serial_bus_arbiter #(
   parameter int NUM_SLAVES = 3,
   parameter int SEL_BITS   = 2,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m1_req,
   input  logic                  m2_req,
   input  logic                  m1_valid,
   input  logic                  m2_valid,
   input  logic                  m1_addr,
   input  logic                  m2_addr,
   input  logic                  m1_data,
   input  logic                  m2_data,
   input  logic                  m1_wren,
   input  logic                  m2_wren,
   input  logic                  m1_burst,
   input  logic                  m2_burst,
   output logic                  m1_grant,
   output logic                  m2_grant,
   output logic                  m1_ready,
   output logic                  m2_ready,
   output logic                  m1_rvalid,
   output logic                  m2_rvalid,
   output logic                  m1_rdata,
   output logic                  m2_rdata,
   output logic [NUM_SLAVES-1:0] s_valid,
   output logic                  s_addr,
   output logic                  s_data,
   output logic                  s_wren,
   output logic                  s_burst,
   input  logic [NUM_SLAVES-1:0] s_ready,
   input  logic [NUM_SLAVES-1:0] s_rvalid,
   input  logic [NUM_SLAVES-1:0] s_rdata,
   output logic                  timeout,
   output logic                  dec_err
);

   // state   | meaning
   // IDLE    | no owner, arbitrate on any request
   // SEL     | owner granted, shifting in the slave-select prefix
   // XFER    | owner connected to the selected slave
   // RELEASE | one-cycle gap with no grant, round-robin pointer updated
   typedef enum logic [1:0] {IDLE, SEL, XFER, RELEASE} stateType;

   localparam int HOLD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int CNT_W  = $clog2(SEL_BITS + 1);

   stateType            stateQ, stateD;
   logic                ownerQ, ownerD;          // 0 = m1, 1 = m2
   logic                lastOwnerQ, lastOwnerD;
   logic [SEL_BITS-1:0] selRegQ, selRegD;
   logic [CNT_W-1:0]    selCntQ, selCntD;
   logic [HOLD_W-1:0]   holdCntQ, holdCntD;
   logic                timeoutQ, timeoutD;
   logic                decErrQ, decErrD;

   logic                ownerReq, ownerValid, ownerAddr;
   logic [SEL_BITS:0]   selShift;
   logic [SEL_BITS-1:0] selNext;
   logic                holdHit, granted;
   logic                selReady, selRvalid, selRdata;
   logic                ownerReady, ownerRvalid, ownerRdata;

   assign ownerReq   = ownerQ ? m2_req   : m1_req;
   assign ownerValid = ownerQ ? m2_valid : m1_valid;
   assign ownerAddr  = ownerQ ? m2_addr  : m1_addr;
   assign selShift   = {selRegQ, ownerAddr};
   assign selNext    = selShift[SEL_BITS-1:0];
   assign holdHit    = (holdCntQ == HOLD_W'(TIMEOUT - 1));
   assign granted    = (stateQ == SEL) || (stateQ == XFER);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ     <= IDLE;
         ownerQ     <= 1'b0;
         lastOwnerQ <= 1'b1;
         selRegQ    <= '0;
         selCntQ    <= '0;
         holdCntQ   <= '0;
         timeoutQ   <= 1'b0;
         decErrQ    <= 1'b0;
      end else begin
         stateQ     <= stateD;
         ownerQ     <= ownerD;
         lastOwnerQ <= lastOwnerD;
         selRegQ    <= selRegD;
         selCntQ    <= selCntD;
         holdCntQ   <= holdCntD;
         timeoutQ   <= timeoutD;
         decErrQ    <= decErrD;
      end
   end

   always_comb begin
      stateD     = stateQ;
      ownerD     = ownerQ;
      lastOwnerD = lastOwnerQ;
      selRegD    = selRegQ;
      selCntD    = selCntQ;
      holdCntD   = holdCntQ;
      timeoutD   = 1'b0;
      decErrD    = 1'b0;
      case (stateQ)
         IDLE: begin
            if (m1_req || m2_req) begin
               ownerD   = (m1_req && m2_req) ? ~lastOwnerQ : m2_req;
               stateD   = SEL;
               selRegD  = '0;
               selCntD  = '0;
               holdCntD = '0;
            end
         end
         SEL, XFER: begin
            holdCntD = holdCntQ + 1'b1;
            // Timeout wins over a simultaneous request drop so the pulse is never lost.
            if (holdHit) begin
               stateD   = RELEASE;
               timeoutD = 1'b1;
            end else if (!ownerReq) begin
               stateD = RELEASE;
            end else if (stateQ == SEL && ownerValid) begin
               selRegD = selNext;
               selCntD = selCntQ + 1'b1;
               if (selCntQ == CNT_W'(SEL_BITS - 1)) begin
                  if (int'(selNext) < NUM_SLAVES) begin
                     stateD = XFER;
                  end else begin
                     stateD  = RELEASE;
                     decErrD = 1'b1;
                  end
               end
            end
         end
         RELEASE: begin
            lastOwnerD = ownerQ;
            stateD     = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      selReady  = 1'b0;
      selRvalid = 1'b0;
      selRdata  = 1'b0;
      s_valid   = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (int'(selRegQ) == i) begin
            selReady   = s_ready[i];
            selRvalid  = s_rvalid[i];
            selRdata   = s_rdata[i];
            s_valid[i] = (stateQ == XFER) && ownerValid;
         end
      end
   end

   assign ownerReady  = (stateQ == SEL) || ((stateQ == XFER) && selReady);
   assign ownerRvalid = (stateQ == XFER) && selRvalid;
   assign ownerRdata  = (stateQ == XFER) && selRdata;

   assign m1_grant  = granted && !ownerQ;
   assign m2_grant  = granted &&  ownerQ;
   assign m1_ready  = ownerReady  && !ownerQ;
   assign m2_ready  = ownerReady  &&  ownerQ;
   assign m1_rvalid = ownerRvalid && !ownerQ;
   assign m2_rvalid = ownerRvalid &&  ownerQ;
   assign m1_rdata  = ownerRdata  && !ownerQ;
   assign m2_rdata  = ownerRdata  &&  ownerQ;

   assign s_addr  = (stateQ == XFER) && ownerAddr;
   assign s_data  = (stateQ == XFER) && (ownerQ ? m2_data  : m1_data);
   assign s_wren  = (stateQ == XFER) && (ownerQ ? m2_wren  : m1_wren);
   assign s_burst = (stateQ == XFER) && (ownerQ ? m2_burst : m1_burst);

   assign timeout = timeoutQ;
   assign dec_err = decErrQ;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: grant/round-robin, prefix decode,
// routing, decode error, hold timeout and asynchronous reset.
module tb_serial_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       m1_req, m2_req, m1_valid, m2_valid, m1_addr, m2_addr;
   logic       m1_data, m2_data, m1_wren, m2_wren, m1_burst, m2_burst;
   logic       m1_grant, m2_grant, m1_ready, m2_ready;
   logic       m1_rvalid, m2_rvalid, m1_rdata, m2_rdata;
   logic [2:0] s_valid, s_ready, s_rvalid, s_rdata;
   logic       s_addr, s_data, s_wren, s_burst, timeout, dec_err;

   int checks   = 0;
   int failures = 0;

   serial_bus_arbiter #(.NUM_SLAVES(3), .SEL_BITS(2), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .m1_req(m1_req), .m2_req(m2_req), .m1_valid(m1_valid), .m2_valid(m2_valid),
      .m1_addr(m1_addr), .m2_addr(m2_addr), .m1_data(m1_data), .m2_data(m2_data),
      .m1_wren(m1_wren), .m2_wren(m2_wren), .m1_burst(m1_burst), .m2_burst(m2_burst),
      .m1_grant(m1_grant), .m2_grant(m2_grant), .m1_ready(m1_ready), .m2_ready(m2_ready),
      .m1_rvalid(m1_rvalid), .m2_rvalid(m2_rvalid), .m1_rdata(m1_rdata), .m2_rdata(m2_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren), .s_burst(s_burst),
      .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .timeout(timeout), .dec_err(dec_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 2 time units after a rising edge; outputs are checked #1 later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] pat;
      int grantCycles;
      int guard;
      reset = 1'b0;
      {m1_req, m2_req, m1_valid, m2_valid, m1_addr, m2_addr} = '0;
      {m1_data, m2_data, m1_wren, m2_wren, m1_burst, m2_burst} = '0;
      s_ready = '0; s_rvalid = '0; s_rdata = '0;
      #1;
      check("rst_grants", {m1_grant, m2_grant}, 2'b00);
      check("rst_pulses", {timeout, dec_err}, 2'b00);
      check("rst_svalid", s_valid, 3'b000);
      step();
      reset = 1'b1;

      // single master, slave 1, prefix "01" then 12 address bits
      m1_req = 1'b1; m1_valid = 1'b1; m1_addr = 1'b0;
      step(); #1;
      check("t1_grant", {m1_grant, m2_grant}, 2'b10);
      check("t1_sel_ready", m1_ready, 1'b1);
      check("t1_sel_sv0", s_valid, 3'b000);
      step();
      m1_addr = 1'b1; #1;
      check("t1_sel_sv1", s_valid, 3'b000);
      step();
      pat = 12'b1011_0010_1101;
      for (int i = 0; i < 12; i++) begin
         m1_valid = (i != 5);
         m1_addr  = pat[11-i];
         m1_data  = pat[i];
         s_ready  = (i == 7) ? 3'b010 : 3'b101;
         #1;
         check("t1_xfer_sv", s_valid, (i != 5) ? 3'b010 : 3'b000);
         check("t1_xfer_addr", {s_addr, s_data}, {pat[11-i], pat[i]});
         check("t1_xfer_ready", m1_ready, (i == 7));
         step();
      end
      s_ready = '0;
      m1_req = 1'b0; m1_valid = 1'b0;
      step(); #1;
      check("t1_release", {m1_grant, m2_grant}, 2'b00);

      // round-robin after a fresh reset
      reset = 1'b0; #3; reset = 1'b1;
      m1_req = 1'b1; m2_req = 1'b1;
      step(); #1;
      check("t2_tie1", {m1_grant, m2_grant}, 2'b10);
      m1_req = 1'b0;
      step(); #1;
      check("t2_release", {m1_grant, m2_grant}, 2'b00);
      step(); #1;
      check("t2_idle", {m1_grant, m2_grant}, 2'b00);
      step(); #1;
      check("t2_m2_grant", {m1_grant, m2_grant}, 2'b01);
      m1_req = 1'b1; m2_req = 1'b0;
      step(); #1;
      check("t2_m2_release", {m1_grant, m2_grant}, 2'b00);
      m2_req = 1'b1;
      step(); step(); #1;
      check("t2_tie2", {m1_grant, m2_grant}, 2'b10);

      // read routing: m2 owns slave 2
      m1_req = 1'b0;
      step(); step(); step(); #1;
      check("t3_grant", {m1_grant, m2_grant}, 2'b01);
      m2_valid = 1'b1; m2_addr = 1'b1; m1_valid = 1'b1;
      step();
      m2_addr = 1'b0;
      step(); #1;
      check("t3_sv_owner", s_valid, 3'b100);
      m2_valid = 1'b0; #1;
      check("t3_sv_nonowner", s_valid, 3'b000);
      s_rvalid = 3'b100; s_rdata = 3'b100; s_ready = 3'b100; #1;
      check("t3_resp_m2", {m2_ready, m2_rvalid, m2_rdata}, 3'b111);
      check("t3_resp_m1", {m1_ready, m1_rvalid, m1_rdata}, 3'b000);
      s_rvalid = 3'b001; s_rdata = 3'b001; s_ready = 3'b001; #1;
      check("t3_other_slave", {m2_ready, m2_rvalid, m2_rdata}, 3'b000);
      s_rvalid = '0; s_rdata = '0; s_ready = '0;
      m2_req = 1'b0; m1_valid = 1'b0;
      step(); step();

      // decode error: prefix "11"
      m1_req = 1'b1; m1_valid = 1'b1; m1_addr = 1'b1;
      step(); #1;
      check("t4_grant", m1_grant, 1'b1);
      step(); #1;
      check("t4_no_err_yet", dec_err, 1'b0);
      step(); #1;
      check("t4_dec_err", {dec_err, m1_grant}, 2'b10);
      check("t4_sv", s_valid, 3'b000);
      m1_req = 1'b0; m1_valid = 1'b0;
      step(); #1;
      check("t4_err_pulse", dec_err, 1'b0);

      // hold timeout with m2 waiting
      m1_req = 1'b1;
      step(); #1;
      m2_req = 1'b1;
      grantCycles = 0;
      guard = 0;
      while (m1_grant && guard < 40) begin
         grantCycles++;
         guard++;
         step(); #1;
      end
      check("t5_guard", (guard < 40), 1'b1);
      check("t5_grant_cycles", grantCycles[15:0], 16'd16);
      check("t5_timeout", {timeout, m1_grant, m2_grant}, 3'b100);
      step(); #1;
      check("t5_timeout_pulse", timeout, 1'b0);
      step(); #1;
      check("t5_m2_grant", {m1_grant, m2_grant}, 2'b01);

      // async reset during a transfer to slave 0
      m2_req = 1'b0; m1_valid = 1'b1; m1_addr = 1'b0;
      step(); step(); step();
      step(); step(); #1;
      check("t6_xfer", {m1_grant, s_valid}, 4'b1001);
      #1; reset = 1'b0; #1;
      check("t6_rst_async", {m1_grant, m2_grant, s_valid}, 5'b00000);
      #2; reset = 1'b1;
      m2_req = 1'b1;
      step(); #1;
      check("t6_tie_after_rst", {m1_grant, m2_grant}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
